clk_div_ctrl: RTL and testbench

Programmable clock-divider controller. Holds the active divide ratio and takes ratio updates over a valid/ready handshake. Each update is applied only at a period boundary, so `clk_out` never produces a runt pulse. Starts and stops the divided clock cleanly on `en`, always ending in the low phase. It sits between the configuration/register logic and the fixed dividers, and replaces hard-wired ratios with a runtime-selectable one.

---
 rtl/clk_div_ctrl.sv | 130 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: runtime ratio via valid/ready, glitch-free start/stop.
// Optional CLK_DIV_CTRL_PCNT_EN adds a 16-bit completed-period counter output.
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             busy,
  output logic [CNT_W-1:0] active_div,
  output logic             div_err
`ifdef CLK_DIV_CTRL_PCNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRun      = 2'd1;
  localparam logic [1:0] StStopping = 2'd2;

  localparam logic [CNT_W-1:0] One = CNT_W'(1);
  localparam logic [CNT_W-1:0] Two = CNT_W'(2);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             err_q, err_d;
  logic             at_end, accept, apply;
  logic [CNT_W-1:0] low_d;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    err_d      = 1'b0;
    at_end     = (k_q == div_q - One);
    accept     = cfg_valid && !pend_q;

    unique case (state_q)
      StIdle: begin
        k_d = '0;
        if (en) state_d = StRun;
      end
      StRun, StStopping: begin
        k_d = at_end ? '0 : k_q + One;
        if (!en && at_end) state_d = StIdle;
        else if (!en)      state_d = StStopping;
        else               state_d = StRun;
      end
      default: begin
        state_d = StIdle;
        k_d     = '0;
      end
    endcase

    // Ratio changes only at a period boundary (or immediately while idle).
    apply = pend_q && ((state_q == StIdle) || at_end);
    if (apply) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end

    // accept requires !pend_q, so it never coincides with apply.
    if (accept) begin
      if (cfg_div < Two) begin
        err_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_div_d = cfg_div;
      end
    end

    low_d     = div_d - (div_d >> 1);
    clk_out_d = (state_d != StIdle) && (k_d >= low_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      div_q      <= CNT_W'(DEFAULT_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      clk_out_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      clk_out_q  <= clk_out_d;
      err_q      <= err_d;
    end
  end

`ifdef CLK_DIV_CTRL_PCNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if ((state_q != StIdle) && at_end) pcnt_d = pcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pcnt_q <= '0;
    else      pcnt_q <= pcnt_d;
  end

  assign period_cnt = pcnt_q;
`endif

  assign cfg_ready  = !pend_q;
  assign clk_out    = clk_out_q;
  assign busy       = (state_q != StIdle);
  assign active_div = div_q;
  assign div_err    = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed table-driven bench for clk_div_ctrl (default parameters CNT_W=8, DEFAULT_DIV=6).
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       clk_out;
  logic       busy;
  logic [7:0] active_div;
  logic       div_err;
`ifdef CLK_DIV_CTRL_PCNT_EN
  logic [15:0] period_cnt;
`endif

  clk_div_ctrl #(
    .CNT_W      (8),
    .DEFAULT_DIV(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .busy      (busy),
    .active_div(active_div),
    .div_err   (div_err)
`ifdef CLK_DIV_CTRL_PCNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] div;
    logic       ck;
    logic       bsy;
    logic       rdy;
    logic [7:0] ad;
    logic       err;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic e, input logic v, input logic [7:0] d, input logic ck,
                     input logic b, input logic r, input logic [7:0] ad, input logic er);
    vec_t t;
    t.en = e; t.vld = v; t.div = d; t.ck = ck; t.bsy = b; t.rdy = r; t.ad = ad; t.err = er;
    vq.push_back(t);
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0d, expected %0d", nm, idx, act, exp);
  endtask

  task automatic step(input logic e, input logic v, input logic [7:0] d);
    en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input int i, input vec_t t);
    check("clk_out", i, 32'(clk_out), 32'(t.ck));
    check("busy", i, 32'(busy), 32'(t.bsy));
    check("cfg_ready", i, 32'(cfg_ready), 32'(t.rdy));
    check("active_div", i, 32'(active_div), 32'(t.ad));
    check("div_err", i, 32'(div_err), 32'(t.err));
  endtask

  initial begin
    // en, vld, div | clk_out, busy, ready, active_div, err  (outputs after the edge)
    add(1,0,0, 0,1,1,6,0); add(1,0,0, 0,1,1,6,0); add(1,0,0, 0,1,1,6,0);
    add(1,0,0, 1,1,1,6,0); add(1,0,0, 1,1,1,6,0); add(1,0,0, 1,1,1,6,0);
    add(1,0,0, 0,1,1,6,0);
    add(1,1,5, 0,1,0,6,0); add(1,0,0, 0,1,0,6,0); add(1,0,0, 1,1,0,6,0);
    add(1,0,0, 1,1,0,6,0); add(1,0,0, 1,1,0,6,0);
    add(1,0,0, 0,1,1,5,0); add(1,0,0, 0,1,1,5,0); add(1,0,0, 0,1,1,5,0);
    add(1,0,0, 1,1,1,5,0); add(1,0,0, 1,1,1,5,0);
    add(1,1,1, 0,1,1,5,1);
    add(1,1,4, 0,1,0,5,0); add(1,0,0, 0,1,0,5,0); add(1,0,0, 1,1,0,5,0);
    add(1,0,0, 1,1,0,5,0);
    add(1,0,0, 0,1,1,4,0); add(1,0,0, 0,1,1,4,0);
    add(0,0,0, 1,1,1,4,0); add(0,0,0, 1,1,1,4,0);
    add(0,0,0, 0,0,1,4,0); add(0,0,0, 0,0,1,4,0);
    add(1,0,0, 0,1,1,4,0); add(1,0,0, 0,1,1,4,0);
    add(0,0,0, 1,1,1,4,0); add(1,0,0, 1,1,1,4,0);
    add(1,0,0, 0,1,1,4,0); add(1,0,0, 0,1,1,4,0); add(1,0,0, 1,1,1,4,0);
    add(1,0,0, 1,1,1,4,0);
    add(0,0,0, 0,0,1,4,0);
    add(0,1,3, 0,0,0,4,0); add(0,0,0, 0,0,1,3,0);
    add(0,1,0, 0,0,1,3,1); add(0,0,0, 0,0,1,3,0);
    add(1,0,0, 0,1,1,3,0); add(1,0,0, 0,1,1,3,0); add(1,0,0, 1,1,1,3,0);
    add(1,0,0, 0,1,1,3,0);

    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_clk_out", 0, 32'(clk_out), 32'd0);
    check("rst_busy", 0, 32'(busy), 32'd0);
    check("rst_cfg_ready", 0, 32'(cfg_ready), 32'd1);
    check("rst_active_div", 0, 32'(active_div), 32'd6);
    check("rst_div_err", 0, 32'(div_err), 32'd0);
`ifdef CLK_DIV_CTRL_PCNT_EN
    check("rst_period_cnt", 0, 32'(period_cnt), 32'd0);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].en, vq[i].vld, vq[i].div);
      check_vec(i, vq[i]);
    end

    // Asynchronous reset while clk_out is high and a ratio is pending.
    step(1'b1, 1'b1, 8'd9);
    check("pend_ready", 0, 32'(cfg_ready), 32'd0);
    begin
      int waited = 0;
      while (!clk_out && waited < 10) begin
        step(1'b1, 1'b0, 8'd0);
        waited++;
      end
      check("wait_clk_out_high", 0, 32'(clk_out), 32'd1);
    end
    #2 rst = 1'b0;
    #1;
    check("async_clk_out", 0, 32'(clk_out), 32'd0);
    check("async_cfg_ready", 0, 32'(cfg_ready), 32'd1);
    check("async_busy", 0, 32'(busy), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_active_div", 0, 32'(active_div), 32'd6);
`ifdef CLK_DIV_CTRL_PCNT_EN
    check("post_rst_period_cnt", 0, 32'(period_cnt), 32'd0);
    for (int i = 0; i < 61; i++) step(1'b1, 1'b0, 8'd0);
    check("period_cnt_10", 0, 32'(period_cnt), 32'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
